// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - single-port SRAM access controller, one operation in flight, fixed read latency
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid, req_ready            request handshake (ready only while idle)
//   req_wen, req_addr, req_wdata    request payload: 1 = write, full address, write data
//   rsp_valid, rsp_rdata            one-cycle read-result pulse, last read data (held)
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata            SRAM macro port
//   busy                            controller not idle
//   op_count                        completed operations, wraps at 256
//   err_drop                        sticky: request presented while not ready
module sram_access_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wen,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic [7:0]        op_count,
   output logic              err_drop
);

   if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_rd_lat
      $error("sram_access_ctrl: RD_LAT must be in the range 1..4");
   end

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

   logic [1:0]        state_q, state_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]        lat_q, lat_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [7:0]        op_count_q, op_count_d;
   logic              err_drop_q, err_drop_d;

   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign mem_en    = (state_q == ST_ISSUE);
   assign mem_we    = (state_q == ST_ISSUE) && wen_q;
   // Address and write data come straight from the capture registers, so
   // they hold the last request outside the ISSUE cycle.
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign op_count  = op_count_q;
   assign err_drop  = err_drop_q;

   always_comb begin
      state_d     = state_q;
      wen_d       = wen_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      lat_d       = lat_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      op_count_d  = op_count_q;
      err_drop_d  = err_drop_q;

      // No queueing: a request seen while busy is dropped and flagged.
      if (req_valid && !req_ready) begin
         err_drop_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               wen_d   = req_wen;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (wen_q) begin
               op_count_d = op_count_q + 8'd1;
               state_d    = ST_IDLE;
            end else begin
               lat_d   = LAT_INIT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Counter value 1 marks the edge at the end of cycle ISSUE+RD_LAT,
            // the only edge where mem_rdata is trusted.
            if (lat_q == 3'd1) begin
               rsp_rdata_d = mem_rdata;
               rsp_valid_d = 1'b1;
               op_count_d  = op_count_q + 8'd1;
               state_d     = ST_IDLE;
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wen_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         lat_q       <= 3'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         op_count_q  <= 8'd0;
         err_drop_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wen_q       <= wen_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         lat_q       <= lat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         op_count_q  <= op_count_d;
         err_drop_q  <= err_drop_d;
      end
   end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - self-checking bench for sram_access_ctrl (RD_LAT 1 and 4 instances)
module tb_sram_access_ctrl;

   localparam int AW  = 10;
   localparam int DW  = 8;
   localparam int LAT = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- RD_LAT = 1 instance ----------------
   logic          rst_n;
   logic          req_valid, req_ready, req_wen;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          busy;
   logic [7:0]    op_count;
   logic          err_drop;

   sram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .op_count(op_count), .err_drop(err_drop)
   );

   // ---------------- RD_LAT = 4 instance ----------------
   logic          b_rst_n;
   logic          b_req_valid, b_req_ready, b_req_wen;
   logic [AW-1:0] b_req_addr;
   logic [DW-1:0] b_req_wdata;
   logic          b_rsp_valid;
   logic [DW-1:0] b_rsp_rdata;
   logic          b_mem_en, b_mem_we;
   logic [AW-1:0] b_mem_addr;
   logic [DW-1:0] b_mem_wdata, b_mem_rdata;
   logic          b_busy;
   logic [7:0]    b_op_count;
   logic          b_err_drop;

   sram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(4)) u_dut4 (
      .clk(clk), .rst_n(b_rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
      .busy(b_busy), .op_count(b_op_count), .err_drop(b_err_drop)
   );

   function automatic logic [7:0] pat(input logic [AW-1:0] a);
      return a[7:0] ^ 8'h1A;
   endfunction

   // SRAM for the RD_LAT=1 instance: registered read; read data is only
   // meaningful in the cycle after the read, junk in every other cycle.
   logic [DW-1:0] sram    [0:1023];
   bit            written [0:1023];
   logic          rd_hit;
   logic [DW-1:0] rd_data, junk;
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         sram[mem_addr]    <= mem_wdata;
         written[mem_addr] <= 1'b1;
      end
      rd_hit  <= mem_en && !mem_we;
      rd_data <= written[mem_addr] ? sram[mem_addr] : pat(mem_addr);
      junk    <= 8'($urandom);
   end
   assign mem_rdata = rd_hit ? rd_data : junk;

   // SRAM for the RD_LAT=4 instance: 4-stage read pipeline, data valid
   // only in cycle ISSUE+4.
   logic [3:0]    b_pv;
   logic [DW-1:0] b_pd0, b_pd1, b_pd2, b_pd3;
   always @(posedge clk) begin
      b_pv  <= {b_pv[2:0], b_mem_en & ~b_mem_we};
      b_pd0 <= pat(b_mem_addr);
      b_pd1 <= b_pd0;
      b_pd2 <= b_pd1;
      b_pd3 <= b_pd2;
   end
   assign b_mem_rdata = b_pv[3] ? b_pd3 : 8'hC3;

   // ---------------- reference model (transaction timing) ----------------
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            free_at = 0, issue_at = -1, inc_at = -1, rsp_at = -1;
   logic [7:0]    op_m = 8'd0;
   logic [DW-1:0] rdata_m = '0, rsp_data_m = '0, wdata_m = '0;
   logic [AW-1:0] addr_m = '0;
   logic          wen_m = 1'b0, err_m = 1'b0;
   logic [DW-1:0] ref_mem [0:1023];
   int            en_cnt = 0, rsp_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   // One clock: model consumes the inputs present at the edge, then the DUT
   // outputs of the new cycle are compared against the model.
   task automatic step();
      bit rdy;
      rdy = (cyc >= free_at);
      @(posedge clk);
      if (!rst_n) begin
         free_at  = cyc + 1;
         issue_at = -1;
         inc_at   = -1;
         rsp_at   = -1;
         op_m     = 8'd0;
         err_m    = 1'b0;
         rdata_m  = '0;
         addr_m   = '0;
         wdata_m  = '0;
         wen_m    = 1'b0;
      end else if (req_valid) begin
         if (rdy) begin
            addr_m   = req_addr;
            wdata_m  = req_wdata;
            wen_m    = req_wen;
            issue_at = cyc + 1;
            if (req_wen) begin
               ref_mem[req_addr] = req_wdata;
               free_at = cyc + 2;
               inc_at  = cyc + 2;
            end else begin
               free_at    = cyc + 2 + LAT;
               inc_at     = free_at;
               rsp_at     = free_at;
               rsp_data_m = ref_mem[req_addr];
            end
         end else begin
            err_m = 1'b1;
         end
      end
      cyc++;
      if (cyc == inc_at) op_m++;
      if (cyc == rsp_at) rdata_m = rsp_data_m;
      #1;
      chk("req_ready", 32'(req_ready), 32'(cyc >= free_at));
      chk("busy",      32'(busy),      32'(cyc < free_at));
      chk("rsp_valid", 32'(rsp_valid), 32'(cyc == rsp_at));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(rdata_m));
      chk("op_count",  32'(op_count),  32'(op_m));
      chk("err_drop",  32'(err_drop),  32'(err_m));
      chk("mem_en",    32'(mem_en),    32'(cyc == issue_at));
      chk("mem_we",    32'(mem_we),    32'((cyc == issue_at) && wen_m));
      chk("mem_addr",  32'(mem_addr),  32'(addr_m));
      chk("mem_wdata", 32'(mem_wdata), 32'(wdata_m));
      en_cnt  += int'(mem_en);
      rsp_cnt += int'(rsp_valid);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 1'b1;     // must be ignored during reset
      req_wen   = 1'b1;
      req_addr  = 10'h155;
      req_wdata = 8'hEE;
      step();
      step();
      rst_n     = 1'b1;
      req_valid = 1'b0;
      chk("rst_err_drop", 32'(err_drop), 32'd0);
   endtask

   task automatic issue(input logic wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = a;
      req_wdata = d;
      step();
      req_valid = 1'b0;
   endtask

   typedef struct {
      logic          wen;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int p1, p2;
      int en_k, en_n, rsp_k, rsp_n;

      tbl[0] = '{1'b1, 10'h3FF, 8'hA5, 8'h00};
      tbl[1] = '{1'b0, 10'h3FF, 8'h00, 8'hA5};
      tbl[2] = '{1'b1, 10'h001, 8'h11, 8'h00};
      tbl[3] = '{1'b1, 10'h002, 8'h22, 8'h00};
      tbl[4] = '{1'b0, 10'h001, 8'h00, 8'h11};
      tbl[5] = '{1'b0, 10'h002, 8'h00, 8'h22};
      tbl[6] = '{1'b0, 10'h040, 8'h00, 8'h5A};
      tbl[7] = '{1'b1, 10'h155, 8'h3C, 8'h00};
      tbl[8] = '{1'b0, 10'h155, 8'h00, 8'h3C};
      tbl[9] = '{1'b0, 10'h3FF, 8'h00, 8'hA5};

      for (int i = 0; i < 1024; i++) ref_mem[i] = pat(10'(i));

      b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_wen = 1'b0;
      b_req_addr = '0; b_req_wdata = '0;
      rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;

      // Reset state
      do_reset();
      b_rst_n = 1'b1;
      chk("rst_ready",    32'(req_ready), 32'd1);
      chk("rst_busy",     32'(busy),      32'd0);
      chk("rst_mem_en",   32'(mem_en),    32'd0);
      chk("rst_mem_addr", 32'(mem_addr),  32'd0);
      chk("rst_op_count", 32'(op_count),  32'd0);
      chk("rst_rdata",    32'(rsp_rdata), 32'd0);

      // Table of back-to-back transactions with fixed expected latency
      for (int i = 0; i < 10; i++) begin
         issue(tbl[i].wen, tbl[i].addr, tbl[i].wdata);
         step();
         if (!tbl[i].wen) step();
         chk("tbl_rsp_valid", 32'(rsp_valid), 32'(!tbl[i].wen));
         if (!tbl[i].wen) chk("tbl_rdata", 32'(rsp_rdata), 32'(tbl[i].exp));
         chk("tbl_op_count", 32'(op_count), i + 1);
      end

      // Read held valid across ISSUE/WAIT: a single access, drop flagged
      do_reset();
      en_cnt = 0;
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 10'h3FF;
      step(); step(); step();
      req_valid = 1'b0;
      step(); step(); step();
      chk("hold_en_count", en_cnt, 1);
      chk("hold_err_drop", 32'(err_drop), 32'd1);
      chk("hold_op_count", 32'(op_count), 32'd1);

      // Reset in the WAIT cycle aborts the read
      do_reset();
      rsp_cnt = 0;
      issue(1'b0, 10'h005, 8'h00);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("abort_ready0", 32'(req_ready), 32'd1);
      step();
      chk("abort_ready1", 32'(req_ready), 32'd1);
      chk("abort_rsp",    rsp_cnt, 0);
      chk("abort_rdata",  32'(rsp_rdata), 32'd0);
      chk("abort_op",     32'(op_count), 32'd0);

      // 256 writes after one read: counter wraps, rsp_rdata untouched
      do_reset();
      issue(1'b0, 10'h3FF, 8'h00);
      step(); step();
      chk("wrap_pre_rdata", 32'(rsp_rdata), 32'hA5);
      rsp_cnt = 0;
      for (int i = 0; i < 256; i++) begin
         issue(1'b1, 10'(10'h200 + i), 8'(i));
         step();
         if (i == 254) chk("wrap_op_zero", 32'(op_count), 32'd0);
      end
      chk("wrap_op_final", 32'(op_count), 32'd1);
      chk("wrap_rdata",    32'(rsp_rdata), 32'hA5);
      chk("wrap_no_rsp",   rsp_cnt, 0);

      // Read accepted in the rsp_valid cycle of the previous read
      do_reset();
      issue(1'b1, 10'h001, 8'h11); step();
      issue(1'b1, 10'h002, 8'h22); step();
      issue(1'b0, 10'h001, 8'h00);
      for (int k = 0; k < 8 && !rsp_valid; k++) step();
      chk("b2b_p1_seen", 32'(rsp_valid), 32'd1);
      chk("b2b_p1_data", 32'(rsp_rdata), 32'h11);
      p1 = cyc;
      issue(1'b0, 10'h002, 8'h00);
      for (int k = 0; k < 8 && !rsp_valid; k++) step();
      p2 = cyc;
      chk("b2b_p2_seen", 32'(rsp_valid), 32'd1);
      chk("b2b_gap",     p2 - p1, 3);
      chk("b2b_p2_data", 32'(rsp_rdata), 32'h22);

      // RD_LAT = 4 instance: read 0x040 (holds 0x5A)
      @(posedge clk); #1;
      b_req_valid = 1'b1; b_req_wen = 1'b0; b_req_addr = 10'h040;
      en_k = -1; en_n = 0; rsp_k = -1; rsp_n = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         b_req_valid = 1'b0;
         if (k == 3) chk("lat4_busy", 32'(b_busy), 32'd1);
         if (b_mem_en) begin
            en_n++; en_k = k;
            chk("lat4_addr", 32'(b_mem_addr), 32'h040);
            chk("lat4_we",   32'(b_mem_we),   32'd0);
         end
         if (b_rsp_valid) begin
            rsp_n++; rsp_k = k;
         end
      end
      chk("lat4_en_cycle",  en_k, 1);
      chk("lat4_en_count",  en_n, 1);
      chk("lat4_rsp_cycle", rsp_k, 6);
      chk("lat4_rsp_count", rsp_n, 1);
      chk("lat4_rdata",     32'(b_rsp_rdata), 32'h5A);
      chk("lat4_op",        32'(b_op_count), 32'd1);
      chk("lat4_err",       32'(b_err_drop), 32'd0);
      chk("lat4_ready",     32'(b_req_ready), 32'd1);
      chk("lat4_wdata",     32'(b_mem_wdata), 32'd0);

      // Randomized traffic with occasional resets against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rst_n     = ($urandom_range(0, 299) != 0);
         req_valid = ($urandom_range(0, 2) != 0);
         req_wen   = 1'($urandom_range(0, 1));
         req_addr  = 10'($urandom_range(0, 15));
         req_wdata = 8'($urandom);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the request and SRAM address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the data width.
REQ-003 Parameter RD_LAT, default 1, SHALL set the SRAM read latency in cycles; legal range 1..4; any other value SHALL fail elaboration.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  1  request strobe from the address/bank front-end.
REQ-007 req_ready  output  1  controller can accept a request this cycle.
REQ-008 req_wen  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_W  full composed address (bank bits + low bits).
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  one-cycle pulse: rsp_rdata updated with read result.
REQ-012 rsp_rdata  output  DATA_W  last read result, held between reads.
REQ-013 mem_en  output  1  SRAM macro enable.
REQ-014 mem_we  output  1  SRAM macro write enable.
REQ-015 mem_addr  output  ADDR_W  SRAM macro address.
REQ-016 mem_wdata  output  DATA_W  SRAM macro write data.
REQ-017 mem_rdata  input  DATA_W  SRAM macro read data.
REQ-018 busy  output  1  state != IDLE.
REQ-019 op_count  output  8  completed-operation counter.
REQ-020 err_drop  output  1  sticky: a request was presented while not ready.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT; req_ready = 1 only in IDLE.
REQ-022 Accept = req_valid & req_ready at a rising edge; on accept, req_wen/req_addr/req_wdata SHALL be captured into internal registers and state SHALL go to ISSUE.
REQ-023 ISSUE lasts exactly one cycle: mem_en = 1, mem_we = captured wen, mem_addr/mem_wdata = captured values.
REQ-024 Outside ISSUE: mem_en = 0, mem_we = 0; mem_addr/mem_wdata SHALL hold the last captured values.
REQ-025 Write: ISSUE -> IDLE; op_count increments at the edge ending ISSUE; no rsp_valid.
REQ-026 Read: ISSUE -> WAIT with latency counter loaded to RD_LAT; counter decrements each WAIT cycle; mem_rdata SHALL be sampled into rsp_rdata at the edge where the counter is 1, i.e. the end of cycle ISSUE+RD_LAT.
REQ-027 rsp_valid SHALL be 1 for exactly the one cycle following that sample edge, in which state is already IDLE (req_ready = 1); op_count increments at the sample edge.
REQ-028 Latency: accept edge at end of cycle A -> ISSUE in A+1; write back in IDLE at A+2; read rsp_valid at A+2+RD_LAT.
REQ-029 Back-to-back: a request accepted in the rsp_valid cycle SHALL be processed normally; max throughput = one op per 2 (write) or 2+RD_LAT (read) cycles.
REQ-030 req_valid = 1 while req_ready = 0 SHALL be ignored (no queueing) and SHALL set err_drop, which stays 1 until reset.
REQ-031 op_count SHALL wrap 255 -> 0 without flag.
REQ-032 rsp_rdata SHALL change only at a read sample edge or reset; writes SHALL NOT alter it.
REQ-033 mem_rdata SHALL be ignored in all cycles other than the sample edge.

Reset
REQ-034 While rst_n = 0 at an edge: state = IDLE, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rsp_valid = 0, rsp_rdata = 0, op_count = 0, err_drop = 0, captured registers = 0.
REQ-035 Reset mid-operation (ISSUE or WAIT) SHALL abort the operation: no rsp_valid, no op_count increment, req_ready = 1 in the first cycle after release.
REQ-036 req_valid during reset SHALL NOT be accepted and SHALL NOT set err_drop.

Verification (RD_LAT = 1 unless stated; SRAM model with 1-cycle read)
REQ-037 Write 0x3FF <- 0xA5, then read 0x3FF -> rsp_valid pulse with rsp_rdata = 0xA5 at accept+3; op_count = 2.
REQ-038 Read request held with req_valid = 1 across ISSUE/WAIT -> only one access issued, err_drop = 1, op_count = 1.
REQ-039 RD_LAT = 4: read of address 0x040 holding 0x5A -> rsp_valid exactly at accept+6, mem_en high exactly one cycle.
REQ-040 rst_n asserted in WAIT cycle -> no rsp_valid, rsp_rdata = 0, op_count = 0, req_ready = 1 one cycle after release.
REQ-041 256 consecutive writes -> op_count = 0 after wrap, rsp_rdata unchanged from prior value, rsp_valid never asserted.
REQ-042 Read accepted in the rsp_valid cycle of a previous read (addr 0x001 = 0x11, then 0x002 = 0x22) -> two pulses 3 cycles apart with 0x11 then 0x22.
